// File: rtl/doodle_jump_engine.sv
// doodle_jump_engine
//   Vertical physics and game-state controller for the doodle. Once per frame tick
//   it moves the doodle up or down one row, detects landings on the platform
//   channels, asks the platform generator to scroll the world once the doodle
//   reaches the scroll line, and keeps a saturating score of scrolled rows.
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | waiting for Start; score of the last game still shown
//   RISE  | jump in progress, JUMP_HEIGHT ticks upward (or scrolling)
//   FALL  | moving down one row per tick, checking for platforms
//   DONE  | doodle hit the floor; everything frozen until Ack
//
// Ports
//   Clk, Reset          system clock, synchronous active-high reset
//   Start, Ack          begin a game (IDLE only) / leave DONE (DONE only)
//   tick                one-clock frame pulse; all motion advances on it
//   doodle_x            doodle left edge
//   plat_x, plat_y      packed platform left edges / top rows, channel i at [i*W +: W]
//   plat_valid          per-channel platform present
//   doodle_y            doodle feet row
//   score               scrolled rows, saturating
//   scroll_step         one-clock pulse: world moved down one row
//   land_pulse          one-clock pulse: landed on a platform
//   land_idx            channel of the most recent landing
//   q_I .. q_Done       one-hot state flags
module doodle_jump_engine #(
    parameter int N_PLAT      = 4,
    parameter int X_W         = 10,
    parameter int Y_W         = 10,
    parameter int SCORE_W     = 16,
    parameter int JUMP_HEIGHT = 64,
    parameter int SCROLL_LINE = 200,
    parameter int START_Y     = 400,
    parameter int SCREEN_H    = 480,
    parameter int DOODLE_W    = 20,
    parameter int PLAT_W      = 40,
    parameter int LIDX_W      = (N_PLAT > 1) ? $clog2(N_PLAT) : 1
) (
    input  logic                    Clk,
    input  logic                    Reset,
    input  logic                    Start,
    input  logic                    Ack,
    input  logic                    tick,
    input  logic [X_W-1:0]          doodle_x,
    input  logic [N_PLAT*X_W-1:0]   plat_x,
    input  logic [N_PLAT*Y_W-1:0]   plat_y,
    input  logic [N_PLAT-1:0]       plat_valid,
    output logic [Y_W-1:0]          doodle_y,
    output logic [SCORE_W-1:0]      score,
    output logic                    scroll_step,
    output logic                    land_pulse,
    output logic [LIDX_W-1:0]       land_idx,
    output logic                    q_I,
    output logic                    q_Rise,
    output logic                    q_Fall,
    output logic                    q_Done
);

    localparam int RC_W = (JUMP_HEIGHT > 1) ? $clog2(JUMP_HEIGHT) : 1;

    // One-hot encoding so the state flags come straight off the state register.
    typedef enum logic [3:0] {
        S_IDLE = 4'b0001,
        S_RISE = 4'b0010,
        S_FALL = 4'b0100,
        S_DONE = 4'b1000
    } state_t;

    state_t              state_q, state_d;
    logic [Y_W-1:0]      doodle_y_q, doodle_y_d;
    logic [SCORE_W-1:0]  score_q, score_d;
    logic [RC_W-1:0]     rise_cnt_q, rise_cnt_d;
    logic                scroll_step_q, scroll_step_d;
    logic                land_pulse_q, land_pulse_d;
    logic [LIDX_W-1:0]   land_idx_q, land_idx_d;

    logic [N_PLAT-1:0]   land_ok;
    logic                land_hit;
    logic [LIDX_W-1:0]   land_hit_idx;

    // Per-channel landing test. Arithmetic is one bit wider than the operands so
    // edges near the top of the coordinate range cannot wrap into a false overlap.
    always_comb begin
        land_ok = '0;
        for (int i = 0; i < N_PLAT; i++) begin
            land_ok[i] = plat_valid[i]
                && (({1'b0, doodle_y_q} + (Y_W+1)'(1)) == {1'b0, plat_y[i*Y_W +: Y_W]})
                && (({1'b0, doodle_x} + (X_W+1)'(DOODLE_W)) > {1'b0, plat_x[i*X_W +: X_W]})
                && ({1'b0, doodle_x} < ({1'b0, plat_x[i*X_W +: X_W]} + (X_W+1)'(PLAT_W)));
        end
    end

    // Scan downward so the lowest qualifying channel is the one left standing.
    always_comb begin
        land_hit     = 1'b0;
        land_hit_idx = '0;
        for (int i = N_PLAT - 1; i >= 0; i--) begin
            if (land_ok[i]) begin
                land_hit     = 1'b1;
                land_hit_idx = LIDX_W'(i);
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        doodle_y_d    = doodle_y_q;
        score_d       = score_q;
        rise_cnt_d    = rise_cnt_q;
        scroll_step_d = 1'b0;
        land_pulse_d  = 1'b0;
        land_idx_d    = land_idx_q;

        case (state_q)
            S_IDLE: begin
                if (Start) begin
                    state_d    = S_RISE;
                    doodle_y_d = Y_W'(START_Y);
                    score_d    = '0;
                    rise_cnt_d = '0;
                end
            end
            S_RISE: begin
                if (tick) begin
                    if (doodle_y_q > Y_W'(SCROLL_LINE)) begin
                        doodle_y_d = doodle_y_q - Y_W'(1);
                    end else begin
                        scroll_step_d = 1'b1;
                        if (score_q != {SCORE_W{1'b1}}) begin
                            score_d = score_q + SCORE_W'(1);
                        end
                    end
                    if (rise_cnt_q == RC_W'(JUMP_HEIGHT - 1)) begin
                        state_d    = S_FALL;
                        rise_cnt_d = '0;
                    end else begin
                        rise_cnt_d = rise_cnt_q + RC_W'(1);
                    end
                end
            end
            S_FALL: begin
                if (tick) begin
                    if (land_hit) begin
                        state_d      = S_RISE;
                        land_pulse_d = 1'b1;
                        land_idx_d   = land_hit_idx;
                        rise_cnt_d   = '0;
                    end else if (doodle_y_q == Y_W'(SCREEN_H - 1)) begin
                        state_d = S_DONE;
                    end else begin
                        doodle_y_d = doodle_y_q + Y_W'(1);
                    end
                end
            end
            S_DONE: begin
                if (Ack) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q       <= S_IDLE;
            doodle_y_q    <= Y_W'(START_Y);
            score_q       <= '0;
            rise_cnt_q    <= '0;
            scroll_step_q <= 1'b0;
            land_pulse_q  <= 1'b0;
            land_idx_q    <= '0;
        end else begin
            state_q       <= state_d;
            doodle_y_q    <= doodle_y_d;
            score_q       <= score_d;
            rise_cnt_q    <= rise_cnt_d;
            scroll_step_q <= scroll_step_d;
            land_pulse_q  <= land_pulse_d;
            land_idx_q    <= land_idx_d;
        end
    end

    assign doodle_y    = doodle_y_q;
    assign score       = score_q;
    assign scroll_step = scroll_step_q;
    assign land_pulse  = land_pulse_q;
    assign land_idx    = land_idx_q;
    assign q_I         = (state_q == S_IDLE);
    assign q_Rise      = (state_q == S_RISE);
    assign q_Fall      = (state_q == S_FALL);
    assign q_Done      = (state_q == S_DONE);

endmodule

// File: tb/tb_doodle_jump_engine.sv
module tb_doodle_jump_engine;

    localparam int N  = 4;
    localparam int XW = 10;
    localparam int YW = 10;
    localparam int JH = 4;
    localparam int SY = 400;
    localparam int SL = 200;
    localparam int FLOOR = 479;

    logic Clk = 1'b0;
    logic Reset = 1'b0, Start = 1'b0, Ack = 1'b0, tick = 1'b0;
    logic [XW-1:0] doodle_x = '0;
    logic [N*XW-1:0] plat_x;
    logic [N*YW-1:0] plat_y;
    logic [N-1:0] plat_valid = '0;
    logic [YW-1:0] doodle_y;
    logic [15:0] score;
    logic scroll_step, land_pulse;
    logic [1:0] land_idx;
    logic q_I, q_Rise, q_Fall, q_Done;

    logic [XW-1:0] px [N];
    logic [YW-1:0] py [N];

    int n_vec = 0;
    int n_err = 0;

    // Reference model: mode 0 idle, 1 rise, 2 fall, 3 done.
    int m_mode = 0, m_y = SY, m_score = 0, m_rises = 0, m_idx = 0;
    bit m_scroll = 0, m_land = 0;

    always #5 Clk = ~Clk;

    always_comb begin
        plat_x = '0;
        plat_y = '0;
        for (int i = 0; i < N; i++) begin
            plat_x[i*XW +: XW] = px[i];
            plat_y[i*YW +: YW] = py[i];
        end
    end

    doodle_jump_engine #(
        .N_PLAT(N), .X_W(XW), .Y_W(YW), .SCORE_W(16), .JUMP_HEIGHT(JH),
        .SCROLL_LINE(SL), .START_Y(SY), .SCREEN_H(480), .DOODLE_W(20), .PLAT_W(40)
    ) dut (
        .Clk(Clk), .Reset(Reset), .Start(Start), .Ack(Ack), .tick(tick),
        .doodle_x(doodle_x), .plat_x(plat_x), .plat_y(plat_y), .plat_valid(plat_valid),
        .doodle_y(doodle_y), .score(score), .scroll_step(scroll_step),
        .land_pulse(land_pulse), .land_idx(land_idx),
        .q_I(q_I), .q_Rise(q_Rise), .q_Fall(q_Fall), .q_Done(q_Done)
    );

    task automatic model_step(input bit r, input bit s, input bit a, input bit t);
        int hit;
        m_scroll = 0;
        m_land   = 0;
        if (r) begin
            m_mode = 0; m_y = SY; m_score = 0; m_rises = 0; m_idx = 0;
            return;
        end
        case (m_mode)
            0: if (s) begin m_mode = 1; m_y = SY; m_score = 0; m_rises = 0; end
            1: if (t) begin
                if (m_y > SL) m_y = m_y - 1;
                else begin
                    m_scroll = 1;
                    if (m_score < 65535) m_score = m_score + 1;
                end
                m_rises = m_rises + 1;
                if (m_rises == JH) begin m_mode = 2; m_rises = 0; end
            end
            2: if (t) begin
                hit = -1;
                for (int i = N - 1; i >= 0; i--) begin
                    if (plat_valid[i] && (m_y + 1 == int'(py[i]))
                        && (int'(doodle_x) + 20 > int'(px[i]))
                        && (int'(doodle_x) < int'(px[i]) + 40))
                        hit = i;
                end
                if (hit >= 0) begin
                    m_mode = 1; m_land = 1; m_idx = hit; m_rises = 0;
                end else if (m_y == FLOOR) m_mode = 3;
                else m_y = m_y + 1;
            end
            default: if (a) m_mode = 0;
        endcase
    endtask

    task automatic cycle(input bit r, input bit s, input bit a, input bit t);
        Reset = r; Start = s; Ack = a; tick = t;
        @(posedge Clk);
        model_step(r, s, a, t);
        #1;
        Reset = 0; Start = 0; Ack = 0; tick = 0;
    endtask

    task automatic clear_plats();
        plat_valid = '0;
        for (int i = 0; i < N; i++) begin px[i] = '0; py[i] = '0; end
    endtask

    // Walk the doodle (via landings on channel 0 and plain falling) to a FALL at target_y.
    task automatic goto_fall(input int target_y);
        clear_plats();
        doodle_x = 10'd100;
        cycle(1, 0, 0, 0);
        cycle(0, 1, 0, 0);
        repeat (JH) cycle(0, 0, 0, 1);
        while (m_y > target_y) begin
            px[0] = 10'd100; py[0] = YW'(m_y + 1); plat_valid = 4'b0001;
            cycle(0, 0, 0, 1);
            clear_plats();
            repeat (JH) cycle(0, 0, 0, 1);
        end
        while (m_y < target_y) cycle(0, 0, 0, 1);
    endtask

    task automatic test_reset();
        clear_plats();
        cycle(1, 0, 0, 1);
        n_vec++; if ({q_I, q_Rise, q_Fall, q_Done} !== 4'b1000) begin n_err++; $display("FAIL reset_state got %b want 1000", {q_I, q_Rise, q_Fall, q_Done}); end
        n_vec++; if (doodle_y !== 10'd400) begin n_err++; $display("FAIL reset_y got %0d want 400", doodle_y); end
        n_vec++; if (score !== 16'd0 || scroll_step !== 1'b0 || land_pulse !== 1'b0 || land_idx !== 2'd0) begin
            n_err++; $display("FAIL reset_outs score=%0d scroll=%b land=%b idx=%0d want 0", score, scroll_step, land_pulse, land_idx); end
        cycle(0, 0, 0, 1);
        n_vec++; if (q_I !== 1'b1 || doodle_y !== 10'd400 || scroll_step !== 1'b0) begin
            n_err++; $display("FAIL idle_tick q_I=%b y=%0d scroll=%b want 1,400,0", q_I, doodle_y, scroll_step); end
        cycle(0, 0, 1, 0);
        n_vec++; if (q_I !== 1'b1) begin n_err++; $display("FAIL idle_ack q_I=%b want 1", q_I); end
    endtask

    task automatic test_rise();
        cycle(1, 0, 0, 0);
        cycle(0, 1, 0, 0);
        n_vec++; if (q_Rise !== 1'b1 || doodle_y !== 10'd400) begin n_err++; $display("FAIL start q_Rise=%b y=%0d want 1,400", q_Rise, doodle_y); end
        for (int k = 1; k <= JH; k++) begin
            cycle(0, 1, 0, 1);
            n_vec++; if (doodle_y !== YW'(SY - k)) begin n_err++; $display("FAIL rise_y%0d got %0d want %0d", k, doodle_y, SY - k); end
            n_vec++; if ({q_Rise, q_Fall} !== ((k == JH) ? 2'b01 : 2'b10)) begin
                n_err++; $display("FAIL rise_state%0d got %b want %b", k, {q_Rise, q_Fall}, (k == JH) ? 2'b01 : 2'b10); end
        end
    endtask

    task automatic test_scroll();
        int exp_y [4] = '{201, 200, 200, 200};
        goto_fall(202);
        px[0] = 10'd100; py[0] = 10'd203; plat_valid = 4'b0001;
        cycle(0, 0, 0, 1);
        clear_plats();
        n_vec++; if (q_Rise !== 1'b1 || doodle_y !== 10'd202 || score !== 16'd0) begin
            n_err++; $display("FAIL scroll_setup q_Rise=%b y=%0d score=%0d want 1,202,0", q_Rise, doodle_y, score); end
        for (int k = 1; k <= JH; k++) begin
            cycle(0, 0, 0, 1);
            n_vec++; if (doodle_y !== YW'(exp_y[k-1])) begin n_err++; $display("FAIL scroll_y%0d got %0d want %0d", k, doodle_y, exp_y[k-1]); end
            n_vec++; if (scroll_step !== (k >= 3)) begin n_err++; $display("FAIL scroll_pulse%0d got %b want %b", k, scroll_step, k >= 3); end
        end
        n_vec++; if (score !== 16'd2) begin n_err++; $display("FAIL scroll_score got %0d want 2", score); end
        cycle(0, 0, 0, 0);
        n_vec++; if (scroll_step !== 1'b0) begin n_err++; $display("FAIL scroll_pulse_width got %b want 0", scroll_step); end
    endtask

    // Continues from test_scroll: FALL at row 200 with score 2.
    task automatic test_reset_mid();
        px[3] = 10'd100; py[3] = 10'd201; plat_valid = 4'b1000;
        cycle(0, 0, 0, 1);
        clear_plats();
        n_vec++; if (land_idx !== 2'd3 || q_Rise !== 1'b1) begin n_err++; $display("FAIL midland idx=%0d q_Rise=%b want 3,1", land_idx, q_Rise); end
        cycle(0, 0, 0, 1);
        n_vec++; if (score !== 16'd3 || scroll_step !== 1'b1) begin n_err++; $display("FAIL mid_score got %0d/%b want 3/1", score, scroll_step); end
        cycle(1, 1, 1, 1);
        n_vec++; if ({q_I, q_Rise, q_Fall, q_Done} !== 4'b1000 || doodle_y !== 10'd400) begin
            n_err++; $display("FAIL midreset state=%b y=%0d want 1000,400", {q_I, q_Rise, q_Fall, q_Done}, doodle_y); end
        n_vec++; if (score !== 16'd0 || scroll_step !== 1'b0 || land_pulse !== 1'b0 || land_idx !== 2'd0) begin
            n_err++; $display("FAIL midreset_outs score=%0d scroll=%b land=%b idx=%0d want 0", score, scroll_step, land_pulse, land_idx); end
    endtask

    task automatic test_land();
        goto_fall(299);
        doodle_x = 10'd100; px[2] = 10'd110; py[2] = 10'd300; plat_valid = 4'b0100;
        px[0] = 10'd100; py[0] = 10'd301; plat_valid[0] = 1'b1;
        cycle(0, 0, 0, 1);
        n_vec++; if (land_pulse !== 1'b1 || land_idx !== 2'd2) begin n_err++; $display("FAIL land pulse=%b idx=%0d want 1,2", land_pulse, land_idx); end
        n_vec++; if (q_Rise !== 1'b1 || doodle_y !== 10'd299) begin n_err++; $display("FAIL land_state q_Rise=%b y=%0d want 1,299", q_Rise, doodle_y); end
        cycle(0, 0, 0, 0);
        n_vec++; if (land_pulse !== 1'b0 || land_idx !== 2'd2) begin n_err++; $display("FAIL land_hold pulse=%b idx=%0d want 0,2", land_pulse, land_idx); end
        clear_plats();
    endtask

    task automatic test_edges();
        goto_fall(299);
        doodle_x = 10'd140; px[0] = 10'd100; py[0] = 10'd300; plat_valid = 4'b0001;
        cycle(0, 0, 0, 1);
        n_vec++; if (land_pulse !== 1'b0 || q_Fall !== 1'b1 || doodle_y !== 10'd300) begin
            n_err++; $display("FAIL edge_right pulse=%b q_Fall=%b y=%0d want 0,1,300", land_pulse, q_Fall, doodle_y); end
        doodle_x = 10'd80; px[0] = 10'd100; py[0] = 10'd301;
        cycle(0, 0, 0, 1);
        n_vec++; if (land_pulse !== 1'b0 || doodle_y !== 10'd301) begin
            n_err++; $display("FAIL edge_left pulse=%b y=%0d want 0,301", land_pulse, doodle_y); end
        doodle_x = 10'd100;
        px[0] = 10'd100; py[0] = 10'd301;
        px[1] = 10'd119; py[1] = 10'd302;
        px[3] = 10'd61;  py[3] = 10'd302;
        plat_valid = 4'b1011;
        cycle(0, 0, 0, 1);
        n_vec++; if (land_pulse !== 1'b1 || land_idx !== 2'd1 || doodle_y !== 10'd301) begin
            n_err++; $display("FAIL edge_prio pulse=%b idx=%0d y=%0d want 1,1,301", land_pulse, land_idx, doodle_y); end
        clear_plats();
    endtask

    task automatic test_floor();
        goto_fall(478);
        cycle(0, 0, 0, 1);
        n_vec++; if (doodle_y !== 10'd479 || q_Fall !== 1'b1) begin n_err++; $display("FAIL floor_y got %0d/%b want 479/1", doodle_y, q_Fall); end
        cycle(0, 0, 0, 1);
        n_vec++; if (q_Done !== 1'b1 || doodle_y !== 10'd479) begin n_err++; $display("FAIL floor_done q_Done=%b y=%0d want 1,479", q_Done, doodle_y); end
        cycle(0, 1, 0, 1);
        cycle(0, 0, 0, 1);
        n_vec++; if (q_Done !== 1'b1 || doodle_y !== 10'd479 || scroll_step !== 1'b0) begin
            n_err++; $display("FAIL done_frozen q_Done=%b y=%0d scroll=%b want 1,479,0", q_Done, doodle_y, scroll_step); end
        cycle(0, 0, 1, 0);
        n_vec++; if (q_I !== 1'b1 || score !== 16'(m_score)) begin n_err++; $display("FAIL done_ack q_I=%b score=%0d want 1,%0d", q_I, score, m_score); end
    endtask

    task automatic test_random();
        clear_plats();
        cycle(1, 0, 0, 0);
        for (int it = 0; it < 3000; it++) begin
            int v;
            bit r, s, a, t;
            doodle_x = XW'($urandom_range(0, 1023));
            for (int i = 0; i < N; i++) begin
                plat_valid[i] = ($urandom_range(0, 2) == 0);
                py[i] = ($urandom_range(0, 1) == 0) ? YW'(m_y + 1) : YW'($urandom_range(0, 479));
                v = int'(doodle_x) + int'($urandom_range(0, 90)) - 45;
                if (v < 0) v = 0;
                if (v > 1023) v = 1023;
                px[i] = XW'(v);
            end
            r = ($urandom_range(0, 399) == 0);
            s = ($urandom_range(0, 7) == 0);
            a = ($urandom_range(0, 7) == 0);
            t = ($urandom_range(0, 1) == 0);
            cycle(r, s, a, t);
            n_vec++; if (doodle_y !== YW'(m_y)) begin n_err++; $display("FAIL rnd_y it=%0d got %0d want %0d", it, doodle_y, m_y); end
            n_vec++; if (score !== 16'(m_score)) begin n_err++; $display("FAIL rnd_score it=%0d got %0d want %0d", it, score, m_score); end
            n_vec++; if (scroll_step !== m_scroll || land_pulse !== m_land) begin
                n_err++; $display("FAIL rnd_pulses it=%0d got %b%b want %b%b", it, scroll_step, land_pulse, m_scroll, m_land); end
            n_vec++; if (land_idx !== 2'(m_idx)) begin n_err++; $display("FAIL rnd_idx it=%0d got %0d want %0d", it, land_idx, m_idx); end
            n_vec++; if ({q_I, q_Rise, q_Fall, q_Done} !== (4'b1000 >> m_mode)) begin
                n_err++; $display("FAIL rnd_state it=%0d got %b want %b", it, {q_I, q_Rise, q_Fall, q_Done}, 4'b1000 >> m_mode); end
        end
    endtask

    initial begin
        clear_plats();
        repeat (2) @(posedge Clk);
        #1;
        test_reset();
        test_rise();
        test_scroll();
        test_reset_mid();
        test_land();
        test_edges();
        test_floor();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
